// File: rtl/cwdma_2d.sv
// cwdma_2d: 2-D output-feature-map address generator driven by tagged instructions,
// with an in-order instruction forwarder and an independent weight-stream skid slice.
module cwdma_2d #(
   parameter int             DW  = 8,
   parameter int             DN  = 6,
   parameter int             AW  = 14,
   parameter int             IW  = 36,
   parameter int             IDW = 4,
   parameter logic [IDW-1:0] ID  = 4'h1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IW-1:0]      inst_m_data,
   input  logic               inst_m_valid,
   output logic               inst_m_ready,
   output logic [IW-1:0]      inst_s_data,
   output logic               inst_s_valid,
   input  logic               inst_s_ready,
   input  logic [DN*DW-1:0]   cwdma_m_data,
   input  logic               cwdma_m_first,
   input  logic               cwdma_m_last,
   input  logic               cwdma_m_valid,
   output logic               cwdma_m_ready,
   output logic [DN*DW-1:0]   cwdma_s_data,
   output logic               cwdma_s_first,
   output logic               cwdma_s_last,
   output logic               cwdma_s_valid,
   input  logic               cwdma_s_ready,
   output logic [AW-1:0]      ofm_addr,
   output logic               ofm_addr_first,
   output logic               ofm_addr_row_last,
   output logic               ofm_addr_last,
   output logic               ofm_addr_valid,
   input  logic               ofm_addr_ready,
   output logic               busy
);

   localparam int PW = DN*DW + 2;

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state_r, state_nxt_s;
   logic              rdy_en_r;
   logic              local_hit_s, local_rdy_s, local_fire_s, fwd_fire_s, addr_fire_s;
   logic [IW-1:0]     fwd_data_r;
   logic              fwd_valid_r;
   logic [8:0]        len_r, col_r;
   logic [4:0]        rep_r, row_r;
   logic [3:0]        gap_r;
   logic [AW-1:0]     row_base_r, addr_r, stride_s, next_base_s;
   logic              first_r, row_last_r, last_r;
   logic [PW-1:0]     out_pl_r, skid_pl_r;
   logic              out_valid_r, skid_valid_r;
   logic              m_fire_s;

   assign local_hit_s  = (inst_m_data[IW-1:32] == ID);
   assign inst_m_ready = local_hit_s ? local_rdy_s
                                     : (rdy_en_r & (~fwd_valid_r | inst_s_ready));
   assign local_fire_s = inst_m_valid & local_hit_s & local_rdy_s;
   assign fwd_fire_s   = inst_m_valid & ~local_hit_s & inst_m_ready;
   assign addr_fire_s  = (state_r == RUN) & ofm_addr_ready;
   assign stride_s     = AW'(len_r) + AW'(gap_r) + {{(AW-1){1'b0}}, 1'b1};
   assign next_base_s  = row_base_r + stride_s;

   // Ready outputs stay low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en_r <= 1'b0;
      else        rdy_en_r <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // FSM next state; a local head is only accepted while idle, so jobs never overlap.
   always_comb begin
      state_nxt_s = state_r;
      local_rdy_s = 1'b0;
      case (state_r)
         IDLE: begin
            local_rdy_s = rdy_en_r;
            if (inst_m_valid && local_hit_s && rdy_en_r) state_nxt_s = RUN;
            else                                         state_nxt_s = IDLE;
         end
         RUN: begin
            if (addr_fire_s && last_r) state_nxt_s = IDLE;
            else                       state_nxt_s = RUN;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Address counters; flags are precomputed for the address being presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r <= 9'd0; rep_r <= 5'd0; gap_r <= 4'd0;
         col_r <= 9'd0; row_r <= 5'd0;
         row_base_r <= '0; addr_r <= '0;
         first_r <= 1'b0; row_last_r <= 1'b0; last_r <= 1'b0;
      end else if (local_fire_s) begin
         len_r      <= inst_m_data[17:9];
         rep_r      <= inst_m_data[8:4];
         gap_r      <= inst_m_data[3:0];
         col_r      <= 9'd0;
         row_r      <= 5'd0;
         row_base_r <= AW'(inst_m_data[31:18]);
         addr_r     <= AW'(inst_m_data[31:18]);
         first_r    <= 1'b1;
         row_last_r <= (inst_m_data[17:9] == 9'd0);
         last_r     <= (inst_m_data[17:9] == 9'd0) && (inst_m_data[8:4] == 5'd0);
      end else if (addr_fire_s) begin
         first_r <= 1'b0;
         if (last_r) begin
            col_r <= 9'd0; row_r <= 5'd0; addr_r <= '0;
            row_last_r <= 1'b0; last_r <= 1'b0;
         end else if (col_r < len_r) begin
            col_r      <= col_r + 9'd1;
            addr_r     <= addr_r + {{(AW-1){1'b0}}, 1'b1};
            row_last_r <= ((col_r + 9'd1) == len_r);
            last_r     <= ((col_r + 9'd1) == len_r) && (row_r == rep_r);
         end else begin
            col_r      <= 9'd0;
            row_r      <= row_r + 5'd1;
            row_base_r <= next_base_s;
            addr_r     <= next_base_s;
            row_last_r <= (len_r == 9'd0);
            last_r     <= (len_r == 9'd0) && ((row_r + 5'd1) == rep_r);
         end
      end else begin
         first_r <= first_r;
      end
   end

   // One-entry forward register for instructions aimed at other blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_data_r  <= '0;
         fwd_valid_r <= 1'b0;
      end else if (fwd_fire_s) begin
         fwd_data_r  <= inst_m_data;
         fwd_valid_r <= 1'b1;
      end else if (inst_s_ready) begin
         fwd_valid_r <= 1'b0;
      end else begin
         fwd_valid_r <= fwd_valid_r;
      end
   end

   assign cwdma_m_ready = rdy_en_r & ~skid_valid_r;
   assign m_fire_s      = cwdma_m_valid & cwdma_m_ready;

   // Weight skid slice: the skid entry absorbs the beat accepted while the output stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pl_r <= '0; out_valid_r <= 1'b0;
         skid_pl_r <= '0; skid_valid_r <= 1'b0;
      end else if (!out_valid_r || cwdma_s_ready) begin
         if (skid_valid_r) begin
            out_pl_r     <= skid_pl_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
         end else if (m_fire_s) begin
            out_pl_r    <= {cwdma_m_data, cwdma_m_first, cwdma_m_last};
            out_valid_r <= 1'b1;
         end else begin
            out_valid_r <= 1'b0;
         end
      end else if (m_fire_s) begin
         skid_pl_r    <= {cwdma_m_data, cwdma_m_first, cwdma_m_last};
         skid_valid_r <= 1'b1;
      end else begin
         skid_valid_r <= skid_valid_r;
      end
   end

   assign {cwdma_s_data, cwdma_s_first, cwdma_s_last} = out_pl_r;
   assign cwdma_s_valid     = out_valid_r;
   assign inst_s_data       = fwd_data_r;
   assign inst_s_valid      = fwd_valid_r;
   assign ofm_addr          = addr_r;
   assign ofm_addr_first    = first_r;
   assign ofm_addr_row_last = row_last_r;
   assign ofm_addr_last     = last_r;
   assign ofm_addr_valid    = (state_r == RUN);
   assign busy              = (state_r == RUN);

endmodule

// File: tb/tb_cwdma_2d.sv
// Directed self-checking bench for cwdma_2d: address jobs, wrap, forwarding,
// weight slice, ready throttling and mid-job reset.
module tb_cwdma_2d;
   localparam int DW = 8, DN = 6, AW = 14, IW = 36;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n = 1'b0;
   logic [IW-1:0]     inst_m_data = '0;
   logic              inst_m_valid = 1'b0, inst_m_ready;
   logic [IW-1:0]     inst_s_data;
   logic              inst_s_valid, inst_s_ready = 1'b1;
   logic [DN*DW-1:0]  cwdma_m_data = '0, cwdma_s_data;
   logic              cwdma_m_first = 1'b0, cwdma_m_last = 1'b0, cwdma_m_valid = 1'b0, cwdma_m_ready;
   logic              cwdma_s_first, cwdma_s_last, cwdma_s_valid, cwdma_s_ready = 1'b1;
   logic [AW-1:0]     ofm_addr;
   logic              ofm_addr_first, ofm_addr_row_last, ofm_addr_last, ofm_addr_valid;
   logic              ofm_addr_ready = 1'b1;
   logic              busy;

   cwdma_2d dut (
      .clk(clk), .rst_n(rst_n),
      .inst_m_data(inst_m_data), .inst_m_valid(inst_m_valid), .inst_m_ready(inst_m_ready),
      .inst_s_data(inst_s_data), .inst_s_valid(inst_s_valid), .inst_s_ready(inst_s_ready),
      .cwdma_m_data(cwdma_m_data), .cwdma_m_first(cwdma_m_first), .cwdma_m_last(cwdma_m_last),
      .cwdma_m_valid(cwdma_m_valid), .cwdma_m_ready(cwdma_m_ready),
      .cwdma_s_data(cwdma_s_data), .cwdma_s_first(cwdma_s_first), .cwdma_s_last(cwdma_s_last),
      .cwdma_s_valid(cwdma_s_valid), .cwdma_s_ready(cwdma_s_ready),
      .ofm_addr(ofm_addr), .ofm_addr_first(ofm_addr_first), .ofm_addr_row_last(ofm_addr_row_last),
      .ofm_addr_last(ofm_addr_last), .ofm_addr_valid(ofm_addr_valid), .ofm_addr_ready(ofm_addr_ready),
      .busy(busy)
   );

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   bit ar_mode = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] mk(input logic [3:0] id, input logic [13:0] base,
                                        input logic [8:0] len, input logic [4:0] rep,
                                        input logic [3:0] gap);
      return {id, base, len, rep, gap};
   endfunction

   function automatic logic [DN*DW-1:0] pat(input int i);
      return {8'(i), 8'hA5, 8'(i*3), 8'h5A, 8'(~i), 8'(i+7)};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Address ready: constant high, or toggled each cycle when ar_mode is set.
   always @(posedge clk) begin
      #1;
      ofm_addr_ready = ar_mode ? ~ofm_addr_ready : 1'b1;
   end

   logic [AW-1:0] q_addr[$];
   logic [2:0]    q_flg[$];
   int            q_cyc[$];
   logic [AW-1:0] ea[$];
   logic [2:0]    ef[$];
   logic          pv = 1'b0, pr = 1'b0;
   logic [AW-1:0] pa = '0;
   logic [2:0]    pf = 3'd0;

   // Address monitor: records transfers and checks that a stalled address holds.
   always @(negedge clk) begin
      if (rst_n && pv && !pr)
         check("addr_hold", {ofm_addr_valid, ofm_addr_first, ofm_addr_row_last, ofm_addr_last, ofm_addr},
               {1'b1, pf, pa});
      if (ofm_addr_valid && ofm_addr_ready) begin
         q_addr.push_back(ofm_addr);
         q_flg.push_back({ofm_addr_first, ofm_addr_row_last, ofm_addr_last});
         q_cyc.push_back(cyc);
      end
      pv <= ofm_addr_valid; pr <= ofm_addr_ready; pa <= ofm_addr;
      pf <= {ofm_addr_first, ofm_addr_row_last, ofm_addr_last};
   end

   task automatic clear_q();
      q_addr.delete(); q_flg.delete(); q_cyc.delete(); ea.delete(); ef.delete();
   endtask

   task automatic send_inst(input logic [IW-1:0] w, output int acc);
      int t = 0;
      @(posedge clk); #1;
      inst_m_data = w; inst_m_valid = 1'b1;
      @(negedge clk);
      while (!inst_m_ready && t < 100) begin @(negedge clk); t++; end
      check("inst_accept", inst_m_ready, 1'b1);
      acc = cyc;
      @(posedge clk); #1;
      inst_m_valid = 1'b0;
   endtask

   task automatic wait_addrs(input int n);
      int t = 0;
      while (q_addr.size() < n && t < 300) begin @(negedge clk); #1; t++; end
   endtask

   task automatic cmp_job(input string tag, input int acc, input bit contig);
      wait_addrs(ea.size());
      check({tag, "_cnt"}, q_addr.size(), ea.size());
      for (int i = 0; i < ea.size() && i < q_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), q_addr[i], ea[i]);
         check($sformatf("%s_flg%0d", tag, i), q_flg[i], ef[i]);
         if (contig && i == 0) check({tag, "_lat"}, q_cyc[0], acc + 1);
         if (contig && i > 0)  check($sformatf("%s_gap%0d", tag, i), q_cyc[i] - q_cyc[i-1], 1);
      end
      @(negedge clk); #1;
      check({tag, "_busy_drop"}, busy, 1'b0);
      check({tag, "_valid_drop"}, ofm_addr_valid, 1'b0);
   endtask

   task automatic run_stream(input bit rand_rdy);
      logic [DN*DW+1:0] rx[$];
      int rxc[$];
      int idx = 0, t0 = 0;
      bit took = 1'b0;
      for (int c = 0; c < 300 && rx.size() < 10; c++) begin
         @(posedge clk); #1;
         if (took) idx++;
         cwdma_m_valid = (idx < 10);
         cwdma_m_data  = pat(idx);
         cwdma_m_first = (idx == 0);
         cwdma_m_last  = (idx == 9);
         cwdma_s_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         took = cwdma_m_valid && cwdma_m_ready;
         if (took && idx == 0) t0 = cyc;
         if (cwdma_s_valid && cwdma_s_ready) begin
            rx.push_back({cwdma_s_data, cwdma_s_first, cwdma_s_last});
            rxc.push_back(cyc);
         end
      end
      @(posedge clk); #1;
      cwdma_m_valid = 1'b0; cwdma_s_ready = 1'b1;
      check("wt_cnt", rx.size(), 10);
      for (int i = 0; i < rx.size(); i++)
         check($sformatf("wt_beat%0d", i), rx[i], {pat(i), i == 0, i == 9});
      if (!rand_rdy && rx.size() == 10) begin
         check("wt_latency", rxc[0], t0 + 1);
         check("wt_rate", rxc[9] - rxc[0], 9);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      logic [IW-1:0] w2, w3;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_vals", {ofm_addr_valid, busy, inst_m_ready, cwdma_m_ready, inst_s_valid,
                         cwdma_s_valid, ofm_addr_first, ofm_addr_row_last, ofm_addr_last}, 9'd0);
      check("rst_addr", ofm_addr, 14'd0);
      check("rst_sdata", {inst_s_data, cwdma_s_data}, '0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("rdy_after_rst", {inst_m_ready, cwdma_m_ready}, 2'b11);

      // Basic 2x4 job with gap
      clear_q();
      for (int i = 0; i < 8; i++) begin
         ea.push_back(14'(16 + (i/4)*6 + i%4));
         ef.push_back({i == 0, i % 4 == 3, i == 7});
      end
      send_inst(mk(4'h1, 14'h0010, 9'd3, 5'd1, 4'd2), acc);
      cmp_job("t1", acc, 1'b1);

      // Wrap past 2^AW
      clear_q();
      ea = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
      ef = '{3'b100, 3'b000, 3'b000, 3'b011};
      send_inst(mk(4'h1, 14'h3FFE, 9'd3, 5'd0, 4'd0), acc);
      cmp_job("t2", acc, 1'b1);

      // Forwarding and in-order stall
      clear_q();
      inst_s_ready = 1'b0;
      w2 = mk(4'h2, 14'h1234, 9'd5, 5'd2, 4'd7);
      w3 = mk(4'h3, 14'h0ABC, 9'd1, 5'd1, 4'd1);
      send_inst(w2, acc);
      check("fwd_valid", inst_s_valid, 1'b1);
      check("fwd_data", inst_s_data, w2);
      ea = '{14'h0155};
      ef = '{3'b111};
      send_inst(mk(4'h1, 14'h0155, 9'd0, 5'd0, 4'd0), acc);
      cmp_job("t3", acc, 1'b1);
      @(posedge clk); #1;
      inst_m_data = w3; inst_m_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("id3_stall", inst_m_ready, 1'b0);
      end
      check("fwd_hold", inst_s_data, w2);
      @(posedge clk); #1;
      inst_s_ready = 1'b1;
      @(negedge clk);
      check("id3_accept", inst_m_ready, 1'b1);
      @(posedge clk); #1;
      inst_m_valid = 1'b0;
      check("fwd_id3", {inst_s_valid, inst_s_data}, {1'b1, w3});
      @(posedge clk); #1;
      check("fwd_drain", inst_s_valid, 1'b0);

      // Weight slice
      run_stream(1'b1);
      run_stream(1'b0);

      // Throttled address ready
      clear_q();
      for (int i = 0; i < 8; i++) begin
         ea.push_back(14'(16 + (i/4)*6 + i%4));
         ef.push_back({i == 0, i % 4 == 3, i == 7});
      end
      ar_mode = 1'b1;
      send_inst(mk(4'h1, 14'h0010, 9'd3, 5'd1, 4'd2), acc);
      cmp_job("t5", acc, 1'b0);
      ar_mode = 1'b0;
      repeat (2) @(posedge clk);

      // Reset in the middle of a job
      clear_q();
      send_inst(mk(4'h1, 14'h0100, 9'd7, 5'd0, 4'd0), acc);
      wait_addrs(2);
      @(posedge clk); #1;
      check("t6_third", ofm_addr, 14'h0102);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {ofm_addr_valid, busy, inst_s_valid, cwdma_s_valid,
                             inst_m_ready, cwdma_m_ready}, 6'd0);
      check("t6_rst_addr", ofm_addr, 14'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("t6_idle", {busy, ofm_addr_valid}, 2'b00);
      clear_q();
      ea = '{14'h0200, 14'h0201};
      ef = '{3'b100, 3'b011};
      send_inst(mk(4'h1, 14'h0200, 9'd1, 5'd0, 4'd0), acc);
      cmp_job("t6", acc, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
